mdu_ctrl: RTL and testbench

Iterative multiply/divide unit with its sequencing FSM and architectural HI/LO registers. It sits beside the combinational ALU in EX.
- Executes MULT/MULTU/DIV/DIVU over 32 iteration cycles, plus MTHI/MTLO as single-cycle writes.
- Exposes busy so the hazard unit stalls the pipeline, and exposes hi/lo directly for MFHI/MFLO.

---
 rtl/mdu_ctrl_pkg.sv | 41 ++++
 rtl/mdu_iter_step.sv | 31 +++
 rtl/mdu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for mdu_ctrl: op-code and FSM-state macros, plus typed
// package enums built from them.
`ifndef MDU_CTRL_DEFS_SVH
`define MDU_CTRL_DEFS_SVH
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`define MDU_OP_WIDTH 3
`define MDU_NOP   3'd0
`define MDU_MULT  3'd1
`define MDU_MULTU 3'd2
`define MDU_DIV   3'd3
`define MDU_DIVU  3'd4
`define MDU_MTHI  3'd5
`define MDU_MTLO  3'd6
`define MDU_IDLE  2'd0
`define MDU_MUL   2'd1
`define MDU_DIV_S 2'd2
`endif

package mdu_ctrl_pkg;

  localparam int MDU_OP_W = `MDU_OP_WIDTH;

  typedef enum logic [`MDU_OP_WIDTH-1:0] {
    OP_NOP   = `MDU_NOP,
    OP_MULT  = `MDU_MULT,
    OP_MULTU = `MDU_MULTU,
    OP_DIV   = `MDU_DIV,
    OP_DIVU  = `MDU_DIVU,
    OP_MTHI  = `MDU_MTHI,
    OP_MTLO  = `MDU_MTLO
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = `MDU_IDLE,
    ST_MUL  = `MDU_MUL,
    ST_DIV  = `MDU_DIV_S
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// divide step on a {upper, lower} 2W-bit accumulator.
module mdu_iter_step #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opr_i,
  input  logic           div_mode_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0]   add_sum;
  logic [W:0]   rem_sh;
  logic [W-1:0] rem_sub;
  logic         rem_geq;

  always_comb begin
    add_sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opr_i} : {(W+1){1'b0}});
    rem_sh  = acc_i[2*W-1:W-1];
    rem_geq = (rem_sh >= {1'b0, opr_i});
    // When the subtract is taken the difference is below the divisor, so W bits suffice.
    rem_sub = rem_sh[W-1:0] - opr_i;
    if (div_mode_i) begin
      if (rem_geq) acc_o = {rem_sub, acc_i[W-2:0], 1'b1};
      else         acc_o = {rem_sh[W-1:0], acc_i[W-2:0], 1'b0};
    end else begin
      acc_o = {add_sum, acc_i[W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers and sequencing FSM.
// Optional MDU_FAST_MUL_EN: MULT/MULTU complete in one cycle via a `*` product.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int W     = `WORD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [`MDU_OP_WIDTH-1:0] mdu_op,
  input  logic [W-1:0]             op1,
  input  logic [W-1:0]             op2,
  input  logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             hi,
  output logic [W-1:0]             lo
);

  // state | meaning
  // IDLE  | accepts new ops; MTHI/MTLO and fast MULT complete here
  // MUL   | shift-add iterations, W cycles
  // DIV   | restoring-divide iterations, W cycles

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  mdu_state_e       state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opr_q, opr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;

  logic           accept, op_is_mul, op_is_div, op_signed;
  logic           s1, s2, last_iter;
  logic [W-1:0]   mag1, mag2, quo, rem;
  logic [2*W-1:0] step_acc;

  assign accept    = start && !flush && (state_q == ST_IDLE);
  assign op_is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign op_is_div = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign op_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
  assign s1        = op_signed && op1[W-1];
  assign s2        = op_signed && op2[W-1];
  // -0x80..0 reads back as 2^(W-1) when treated as unsigned, which is the correct magnitude.
  assign mag1      = s1 ? -op1 : op1;
  assign mag2      = s2 ? -op2 : op2;
  assign last_iter = (cnt_q == '0);
  assign quo       = step_acc[W-1:0];
  assign rem       = step_acc[2*W-1:W];

  mdu_iter_step #(.W(W)) u_step (
    .acc_i      (acc_q),
    .opr_i      (opr_q),
    .div_mode_i (state_q == ST_DIV),
    .acc_o      (step_acc)
  );

`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      opr_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opr_q   <= opr_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifndef MDU_FAST_MUL_EN
          if (op_is_mul) state_d = ST_MUL;
`endif
          if (op_is_div) state_d = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush || last_iter) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    opr_d  = opr_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        if (op_is_mul) begin
`ifdef MDU_FAST_MUL_EN
          {hi_d, lo_d} = (s1 ^ s2) ? -fast_prod : fast_prod;
          done_d       = 1'b1;
`else
          acc_d = {{W{1'b0}}, mag2};
          opr_d = mag1;
          neg_d = s1 ^ s2;
          cnt_d = CNT_LAST;
`endif
        end else if (op_is_div) begin
          acc_d  = {{W{1'b0}}, mag1};
          opr_d  = mag2;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          cnt_d  = CNT_LAST;
        end else if (mdu_op == OP_MTHI) begin
          hi_d = op1;
        end else if (mdu_op == OP_MTLO) begin
          lo_d = op1;
        end
      end
    end else if (flush) begin
      cnt_d = '0;
    end else begin
      acc_d = step_acc;
      cnt_d = last_iter ? '0 : cnt_q - CNT_W'(1);
      if (last_iter) begin
        done_d = 1'b1;
        if (state_q == ST_MUL) begin
          {hi_d, lo_d} = neg_q ? -step_acc : step_acc;
        end else begin
          lo_d = neg_q  ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (iterative or MDU_FAST_MUL_EN build).
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 32;
`endif
  localparam int DIV_CYC = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mdu_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mdu_op (mdu_op),
    .op1    (op1),
    .op2    (op2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op, counts busy cycles, optionally pokes an MTHI during busy.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int cyc, input int inject);
    int n;
    logic unstable, early_done;
    logic [31:0] pre_hi, pre_lo;
    mdu_op = op; op1 = a; op2 = b; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0; unstable = 1'b0; early_done = 1'b0;
    pre_hi = hi; pre_lo = lo;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (hi !== pre_hi || lo !== pre_lo) unstable = 1'b1;
      if (done !== 1'b0) early_done = 1'b1;
      if (n == inject) begin
        start = 1'b1; mdu_op = OP_MTHI; op1 = 32'hDEAD;
      end
      tick;
      start = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(cyc));
    chk({tag, "_stable"}, {62'd0, unstable, early_done}, 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    tick;
    chk({tag, "_done_clr"}, 64'(done), 64'd0);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick;
    chk("idle_done", 64'(done), 64'd0);

    // multiply
    run_op("mult_m2x3",   OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_CYC, 0);
    run_op("multu_m2x3",  OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MUL_CYC, 0);
    run_op("mult_6x7",    OP_MULT,  32'd6, 32'd7, 32'd0, 32'd42, MUL_CYC, 0);
    run_op("mult_min2",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0, MUL_CYC, 0);

    // divide
    run_op("div_m7by2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC, 0);
    run_op("divu_7by2",   OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DIV_CYC, 0);
    run_op("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DIV_CYC, 0);
    run_op("divu_max16",  OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, DIV_CYC, 0);
    run_op("divu_5by0",   OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DIV_CYC, 0);
    run_op("div_m5by0",   OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'd1, DIV_CYC, 0);
    run_op("div_7by0",    OP_DIV,  32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, DIV_CYC, 0);

    // start during busy is ignored
    run_op("divu_inject", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, DIV_CYC, 5);

    // MTHI / MTLO
    mdu_op = OP_MTHI; op1 = 32'hABCD; start = 1'b1;
    tick;
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h0000ABCD);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    tick;
    chk("mthi_done2", 64'(done), 64'd0);
    mdu_op = OP_MTHI; op1 = 32'h11; start = 1'b1;
    tick;
    mdu_op = OP_MTLO; op1 = 32'h22;
    tick;
    start = 1'b0;
    chk("mt_hi11", 64'(hi), 64'h11);
    chk("mtlo_lo22", 64'(lo), 64'h22);

    // flush mid-divide
    mdu_op = OP_DIV; op1 = 32'd100; op2 = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'h11);
    chk("flush_lo", 64'(lo), 64'h22);
    tick;
    chk("flush_done2", 64'(done), 64'd0);
    repeat (30) tick;
    chk("flush_late", {30'd0, busy, done, hi, lo}, {34'd0, 32'h22} | (64'h11 << 32));

    // flush with start: nothing happens
    mdu_op = OP_DIVU; op1 = 32'd9; op2 = 32'd2; start = 1'b1; flush = 1'b1;
    tick;
    chk("fs_div_busy", 64'(busy), 64'd0);
    mdu_op = OP_MTLO; op1 = 32'h99;
    tick;
    start = 1'b0; flush = 1'b0;
    chk("fs_mtlo_lo", 64'(lo), 64'h22);
    chk("fs_done", 64'(done), 64'd0);
    chk("fs_hi", 64'(hi), 64'h11);

    // NOP with start has no effect
    mdu_op = OP_NOP; op1 = 32'h55; start = 1'b1;
    tick;
    start = 1'b0;
    chk("nop_state", {30'd0, busy, done, hi, lo}, (64'h11 << 32) | 64'h22);

    // reset mid-divide aborts without writing
    mdu_op = OP_DIVU; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_hilo", {hi, lo}, 64'd0);
    repeat (35) tick;
    chk("rstmid_late", {30'd0, busy, done, hi, lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
